// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// PLL bring-up supervisor: holds the PLL in reset, waits for lock with a timeout and retries,
// qualifies lock, then releases downstream channel resets one by one. Lock loss re-runs the sequence.
module pll_lock_supervisor #(
    parameter int NUM_CH              = 4,
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                               clk_in,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               pll_lock_async,
    output logic                               pll_reset,
    output logic                               locked,
    output logic [NUM_CH-1:0]                  ch_reset,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         loss_count
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The release window length is folded in so the counter always covers the whole stagger.
    localparam int MAXP = max2(max2(max2(RST_HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                    max2(LOCK_TIMEOUT_CYCLES, STAGGER_CYCLES)),
                               max2(MAX_RETRIES, NUM_CH * STAGGER_CYCLES));
    localparam int CW   = $clog2(MAXP) + 1;
    localparam int RW   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_WAIT, S_STABLE, S_RELEASE, S_RUN, S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_next;
    logic              r_lock_meta;
    logic              r_lock_s;
    logic              r_pll_reset;
    logic              r_locked;
    logic              r_fault;
    logic [NUM_CH-1:0] r_ch_reset;
    logic [RW-1:0]     r_retry;
    logic [7:0]        r_loss;

    logic              w_pll_reset_next;
    logic              w_locked_next;
    logic              w_fault_next;
    logic [NUM_CH-1:0] w_ch_reset_next;
    logic [NUM_CH-1:0] w_ch_hit;
    logic [RW-1:0]     w_retry_next;
    logic [RW-1:0]     w_retry_inc;
    logic [7:0]        w_loss_next;
    logic              w_timeout;
    logic              w_lock_loss;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock_async;
            r_lock_s    <= r_lock_meta;
        end
    end

    assign w_retry_inc = r_retry + 1'b1;
    assign w_timeout   = (r_state == S_WAIT) && !r_lock_s &&
                         (r_cnt == CW'(LOCK_TIMEOUT_CYCLES - 1));
    assign w_lock_loss = ((r_state == S_RELEASE) || (r_state == S_RUN)) && !r_lock_s;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (enable) w_next = S_HOLD;
            S_HOLD:    if (r_cnt == CW'(RST_HOLD_CYCLES - 1)) w_next = S_WAIT;
            S_WAIT: begin
                if (r_lock_s)       w_next = S_STABLE;
                else if (w_timeout) w_next = (w_retry_inc == RW'(MAX_RETRIES)) ? S_FAULT : S_HOLD;
            end
            S_STABLE: begin
                if (!r_lock_s) w_next = S_WAIT;
                else if (r_cnt == CW'(LOCK_STABLE_CYCLES - 1)) w_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!r_lock_s) w_next = S_HOLD;
                else if (r_cnt == CW'(NUM_CH * STAGGER_CYCLES - 1)) w_next = S_RUN;
            end
            S_RUN:     if (!r_lock_s) w_next = S_HOLD;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
        // Dropping enable overrides every other transition.
        if (!enable && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_ch_hit[gi] = (r_state == S_RELEASE) &&
                                  (r_cnt == CW'((gi + 1) * STAGGER_CYCLES - 1));
        end
    endgenerate

    always_comb begin
        w_pll_reset_next = (w_next == S_IDLE) || (w_next == S_HOLD) || (w_next == S_FAULT);
        w_locked_next    = (w_next == S_RELEASE) || (w_next == S_RUN);
        w_fault_next     = (w_next == S_FAULT);

        w_ch_reset_next = r_ch_reset & ~w_ch_hit;
        if (!w_locked_next) w_ch_reset_next = '1;

        w_retry_next = r_retry;
        if (w_timeout) w_retry_next = w_retry_inc;
        if ((r_state == S_STABLE) && (w_next == S_RELEASE)) w_retry_next = '0;
        if (w_next == S_IDLE) w_retry_next = '0;

        w_loss_next = r_loss;
        if (w_lock_loss && (w_next == S_HOLD) && (r_loss != 8'd255)) w_loss_next = r_loss + 8'd1;

        w_cnt_next = '0;
        if ((w_next == r_state) &&
            ((r_state == S_HOLD) || (r_state == S_WAIT) ||
             (r_state == S_STABLE) || (r_state == S_RELEASE)))
            w_cnt_next = r_cnt + 1'b1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_ch_reset  <= '1;
            r_retry     <= '0;
            r_loss      <= '0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_pll_reset <= w_pll_reset_next;
            r_locked    <= w_locked_next;
            r_fault     <= w_fault_next;
            r_ch_reset  <= w_ch_reset_next;
            r_retry     <= w_retry_next;
            r_loss      <= w_loss_next;
        end
    end

    assign pll_reset   = r_pll_reset;
    assign locked      = r_locked;
    assign fault       = r_fault;
    assign ch_reset    = r_ch_reset;
    assign retry_count = r_retry;
    assign loss_count  = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// Directed bench for pll_lock_supervisor: a vector table for bring-up and lock loss,
// plus hand sequences for timeout/fault, glitches, enable drop and async reset.
module tb_pll_lock_supervisor;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b0;
    logic       pll_lock_async = 1'b0;
    logic       pll_reset;
    logic       locked;
    logic [3:0] ch_reset;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] loss_count;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .NUM_CH(4), .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8),
        .LOCK_TIMEOUT_CYCLES(32), .STAGGER_CYCLES(2), .MAX_RETRIES(2)
    ) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .pll_lock_async(pll_lock_async),
        .pll_reset(pll_reset), .locked(locked), .ch_reset(ch_reset), .fault(fault),
        .retry_count(retry_count), .loss_count(loss_count)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic       lock;
        int         n;
        logic       pll;
        logic       lkd;
        logic [3:0] ch;
        logic       flt;
        logic [1:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", tag, nm, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_pll, input logic e_lkd,
                              input logic [3:0] e_ch, input logic e_flt,
                              input logic [1:0] e_rc, input logic [7:0] e_lc);
        chk(tag, "pll_reset",   32'(pll_reset),   32'(e_pll));
        chk(tag, "locked",      32'(locked),      32'(e_lkd));
        chk(tag, "ch_reset",    32'(ch_reset),    32'(e_ch));
        chk(tag, "fault",       32'(fault),       32'(e_flt));
        chk(tag, "retry_count", 32'(retry_count), 32'(e_rc));
        chk(tag, "loss_count",  32'(loss_count),  32'(e_lc));
        $display("%s: pll_reset=%0b locked=%0b ch_reset=%h fault=%0b retry=%0d loss=%0d",
                 tag, pll_reset, locked, ch_reset, fault, retry_count, loss_count);
    endtask

    // Inputs change 1 ns after a rising edge; outputs are sampled at the same offset.
    task automatic run(input logic en, input logic lk, input int n);
        enable = en;
        pll_lock_async = lk;
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        enable = 1'b0;
        pll_lock_async = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        reset = 1'b0;
        check_outs(tag, 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
    endtask

    initial begin
        // Edge numbers in comments count rising edges after reset release.
        tbl[0]  = '{1'b1, 1'b0, 4,  1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0}; // E4  hold
        tbl[1]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0}; // E5  pll out of reset
        tbl[2]  = '{1'b1, 1'b0, 4,  1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0}; // E9
        tbl[3]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0}; // E19 stable since E12
        tbl[4]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0}; // E20 locked
        tbl[5]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0}; // E21
        tbl[6]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 4'hE, 1'b0, 2'd0, 8'd0}; // E22 ch0
        tbl[7]  = '{1'b1, 1'b1, 2,  1'b0, 1'b1, 4'hC, 1'b0, 2'd0, 8'd0}; // E24 ch1
        tbl[8]  = '{1'b1, 1'b1, 2,  1'b0, 1'b1, 4'h8, 1'b0, 2'd0, 8'd0}; // E26 ch2
        tbl[9]  = '{1'b1, 1'b1, 2,  1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0}; // E28 ch3, RUN
        tbl[10] = '{1'b1, 1'b1, 5,  1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0}; // E33 RUN steady
        tbl[11] = '{1'b1, 1'b0, 2,  1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd0}; // E35 loss in flight
        tbl[12] = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1}; // E36 loss seen
        tbl[13] = '{1'b1, 1'b1, 3,  1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1}; // E39 still holding
        tbl[14] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1}; // E40 wait lock
        tbl[15] = '{1'b1, 1'b1, 1,  1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1}; // E41 stable
        tbl[16] = '{1'b1, 1'b1, 7,  1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd1}; // E48
        tbl[17] = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd1}; // E49 relocked
        tbl[18] = '{1'b1, 1'b1, 2,  1'b0, 1'b1, 4'hE, 1'b0, 2'd0, 8'd1}; // E51
        tbl[19] = '{1'b1, 1'b1, 6,  1'b0, 1'b1, 4'h0, 1'b0, 2'd0, 8'd1}; // E57 RUN again

        repeat (3) @(posedge clk_in);
        #1;
        reset = 1'b0;
        check_outs("reset_values", 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);

        for (int i = 0; i < 20; i++) begin
            run(tbl[i].en, tbl[i].lock, tbl[i].n);
            check_outs($sformatf("vec%0d", i), tbl[i].pll, tbl[i].lkd, tbl[i].ch,
                       tbl[i].flt, tbl[i].rc, tbl[i].lc);
        end

        // Second loss, then async reset while in WAIT_LOCK.
        run(1'b1, 1'b0, 3);
        check_outs("loss2", 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd2);
        run(1'b1, 1'b0, 5);
        check_outs("wait_before_rst", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd2);
        #3 reset = 1'b1;
        #1;
        check_outs("async_reset", 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);

        // Timeout to fault.
        do_reset("rst_timeout");
        run(1'b1, 1'b0, 36);
        check_outs("to_E36", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b1, 1'b0, 1);
        check_outs("to_retry1", 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0);
        run(1'b1, 1'b0, 4);
        check_outs("to_wait2", 1'b0, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0);
        run(1'b1, 1'b0, 31);
        check_outs("to_E72", 1'b0, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0);
        run(1'b1, 1'b0, 1);
        check_outs("to_fault", 1'b1, 1'b0, 4'hF, 1'b1, 2'd2, 8'd0);
        run(1'b1, 1'b1, 5);
        check_outs("fault_sticky", 1'b1, 1'b0, 4'hF, 1'b1, 2'd2, 8'd0);
        run(1'b0, 1'b0, 1);
        check_outs("fault_exit", 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);

        // Lock arrives on the cycle the timeout would fire: lock wins.
        do_reset("rst_race");
        run(1'b1, 1'b0, 34);
        check_outs("race_E34", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b1, 1'b1, 3);
        check_outs("race_E37", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b1, 1'b1, 7);
        check_outs("race_E44", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b1, 1'b1, 1);
        check_outs("race_locked", 1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0);

        // One timeout, then success clears retry_count.
        do_reset("rst_retry");
        run(1'b1, 1'b0, 37);
        check_outs("retry_E37", 1'b1, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0);
        run(1'b1, 1'b0, 4);
        check_outs("retry_E41", 1'b0, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0);
        run(1'b1, 1'b1, 10);
        check_outs("retry_E51", 1'b0, 1'b0, 4'hF, 1'b0, 2'd1, 8'd0);
        run(1'b1, 1'b1, 1);
        check_outs("retry_clear", 1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0);

        // One-cycle lock glitch at STABLE cycle 5.
        do_reset("rst_glitch");
        run(1'b1, 1'b0, 9);
        run(1'b1, 1'b1, 6);
        run(1'b1, 1'b0, 1);
        run(1'b1, 1'b1, 4);
        check_outs("glitch_E20", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b1, 1'b1, 6);
        check_outs("glitch_E26", 1'b0, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b1, 1'b1, 1);
        check_outs("glitch_locked", 1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 8'd0);

        // enable drop after channel 1 release.
        do_reset("rst_endrop");
        run(1'b1, 1'b0, 9);
        run(1'b1, 1'b1, 15);
        check_outs("endrop_E24", 1'b0, 1'b1, 4'hC, 1'b0, 2'd0, 8'd0);
        run(1'b0, 1'b1, 1);
        check_outs("endrop_idle", 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);
        run(1'b0, 1'b0, 2);
        check_outs("endrop_stay", 1'b1, 1'b0, 4'hF, 1'b0, 2'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
